// File: rtl/rotating_priority_arbiter_if.sv
// Request/grant bundle between requesters and rotating_priority_arbiter.
// The master side drives requests; the slave side (the arbiter) returns grant state.
interface rotating_priority_arbiter_if #(
    parameter int SIZE = 4
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    logic [SIZE-1:0]  requests;
    logic [SIZE-1:0]  grant;
    logic [IDX_W-1:0] grant_index;
    logic             busy;

    modport master (
        output requests,
        input  grant,
        input  grant_index,
        input  busy
    );

    modport slave (
        input  requests,
        output grant,
        output grant_index,
        output busy
    );
endinterface

// File: rtl/rotating_priority_arbiter.sv
// Round-robin arbiter with a rotating priority pointer and non-preemptive grants.
// Optional hold limit enabled by defining ROTATING_PRIORITY_ARBITER_TIMEOUT_EN.
module rotating_priority_arbiter #(
    parameter int SIZE    = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                          clock,
    input  logic                          resetn,
    rotating_priority_arbiter_if.slave    arb
);
    localparam int IDX_W = (SIZE > 1) ? $clog2(SIZE) : 1;

    if (SIZE < 2 || TIMEOUT < 1) begin : g_param_check
        $error("rotating_priority_arbiter: SIZE must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [SIZE-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;

    logic [SIZE-1:0]  req_sel_s;
    logic             found_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] ptr_next_s;

`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    // Winner search: first candidate request at or after the pointer, wrapping.
    always_comb begin
        req_sel_s = arb.requests;
        if (state_q == GRANTED) begin
            req_sel_s[idx_q] = 1'b0;
        end else begin
            req_sel_s = arb.requests;
        end
        found_s  = 1'b0;
        winner_s = {IDX_W{1'b0}};
        for (int i = 0; i < SIZE; i++) begin
            int               cand;
            logic [IDX_W-1:0] cand_w;
            cand = int'(ptr_q) + i;
            if (cand >= SIZE) begin
                cand = cand - SIZE;
            end else begin
                cand = cand;
            end
            cand_w = IDX_W'(cand);
            if (!found_s && req_sel_s[cand_w]) begin
                found_s  = 1'b1;
                winner_s = cand_w;
            end else begin
                found_s  = found_s;
            end
        end
        if (winner_s == IDX_W'(SIZE - 1)) begin
            ptr_next_s = {IDX_W{1'b0}};
        end else begin
            ptr_next_s = winner_s + IDX_W'(1);
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d          = GRANTED;
                    grant_d          = {SIZE{1'b0}};
                    grant_d[winner_s] = 1'b1;
                    idx_d            = winner_s;
                    busy_d           = 1'b1;
                    ptr_d            = ptr_next_s;
`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
                    cnt_d            = {CNT_W{1'b0}};
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            GRANTED: begin
                if (!arb.requests[idx_q]) begin
                    // Released: hand straight over, or fall back to IDLE.
                    if (found_s) begin
                        state_d           = GRANTED;
                        grant_d           = {SIZE{1'b0}};
                        grant_d[winner_s] = 1'b1;
                        idx_d             = winner_s;
                        busy_d            = 1'b1;
                        ptr_d             = ptr_next_s;
`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
                        cnt_d             = {CNT_W{1'b0}};
`endif
                    end else begin
                        state_d = IDLE;
                        grant_d = {SIZE{1'b0}};
                        idx_d   = {IDX_W{1'b0}};
                        busy_d  = 1'b0;
                    end
                end else begin
`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
                    // Hold limit reached: pointer already ranks this requester last.
                    if (cnt_q == CNT_MAX) begin
                        state_d = IDLE;
                        grant_d = {SIZE{1'b0}};
                        idx_d   = {IDX_W{1'b0}};
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`else
                    state_d = GRANTED;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = {SIZE{1'b0}};
                idx_d   = {IDX_W{1'b0}};
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= {IDX_W{1'b0}};
            grant_q <= {SIZE{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            busy_q  <= 1'b0;
`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
            cnt_q   <= {CNT_W{1'b0}};
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
`ifdef ROTATING_PRIORITY_ARBITER_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign arb.grant       = grant_q;
    assign arb.grant_index = idx_q;
    assign arb.busy        = busy_q;

endmodule

// File: doc/rotating_priority_arbiter.md
ROTATING_PRIORITY_ARBITER -- requirements
Module: rotating_priority_arbiter

Interface
REQ-001 SHALL have parameter SIZE, default 4: number of requesters; legal values are 2 or more.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum grant hold in cycles; legal values are 1 or more; used only under REQ-021.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port requests, input, SIZE bits: per-requester request level; bit i belongs to requester i.
REQ-006 SHALL have port grant, output, SIZE bits: registered, one-hot or zero.
REQ-007 SHALL have port grant_index, output, max(1,clog2(SIZE)) bits: registered binary index of the granted requester.
REQ-008 SHALL have port busy, output, 1 bit: registered; high exactly when grant is non-zero.

Function
REQ-009 SHALL implement two states: IDLE (grant=0) and GRANTED (exactly one grant bit set).
REQ-010 SHALL hold a priority pointer P in 0..SIZE-1; requester P has highest priority, then P+1, ... wrapping modulo SIZE.
REQ-011 SHALL select the winner as the first asserted requests bit at or after P in wrap-around order (rotate requests right by P, take lowest set bit, add P modulo SIZE).
REQ-012 SHALL, in IDLE with any requests bit high, enter GRANTED at the next edge with grant=onehot(winner), grant_index=winner and P=(winner+1) mod SIZE; latency is 1 cycle from request to grant.
REQ-013 SHALL, in IDLE with requests=0, stay in IDLE with P unchanged.
REQ-014 SHALL, in GRANTED, hold grant, grant_index and P unchanged while requests[grant_index] stays high; other requests never preempt.
REQ-015 SHALL, in GRANTED when requests[grant_index] is low at an edge, hand over at that edge to the REQ-011 winner, with updated P and no idle cycle; if no other request is high, return to IDLE.
REQ-016 SHALL ignore the released requester's own bit in the REQ-015 handover selection; the pointer already ranks it last.
REQ-017 SHALL, when P wraps (winner SIZE-1), set P=0.
REQ-018 SHALL never drive grant with more than one bit set, nor set a grant bit whose request was low at the deciding edge.

Reset
REQ-019 SHALL, while resetn is low, asynchronously force grant=0, grant_index=0, busy=0, P=0, state IDLE and the timeout counter to 0, regardless of the current state.
REQ-020 SHALL, after resetn rises, first arbitrate at the first rising clock edge, with P=0.

Configuration
REQ-021 SHALL, with ROTATING_PRIORITY_ARBITER_TIMEOUT_EN defined, have a hold counter that clears on every new grant and increments each GRANTED cycle.
REQ-022 SHALL, under that macro, leave grant high for exactly TIMEOUT cycles while its request stays high, then deassert it for one cycle (IDLE) before normal arbitration; P already points past the preempted requester.
REQ-023 SHALL, without the macro, have no counter logic and let the grant persist indefinitely while its request is held.

Verification (SIZE=4; TIMEOUT=3 where the macro applies)
REQ-024 SHALL cover rotation: requests=1111 held from reset gives grant=0001. Dropping each winner's bit in turn gives 0010, 0100, 1000 on successive edges. Re-raising all bits then gives 0001 (wrap, P=0).
REQ-025 SHALL cover pointer priority: requests=0110 gives grant=0010 and P=2. Dropping bit 1 while 0101 is held gives grant=0100 at that edge with no gap, and P=3.
REQ-026 SHALL cover no preemption and idle return: requests=0001 gives grant=0001. Raising bit 3 leaves grant=0001. Dropping bit 0 and bit 3 together gives grant=0000 and busy=0 at the next edge.
REQ-027 SHALL cover async reset: resetn low mid-cycle while grant=0100 gives grant=0000, grant_index=0 and busy=0 before the next edge. After release with requests=0100, grant=0100 at the first edge.
REQ-028 SHALL cover timeout with the macro: requests=0011 held gives grant=0001 for 3 cycles, then 0000 for 1 cycle, then 0010 for 3 cycles, then 0000, then 0001.
REQ-029 SHALL cover the same stimulus without the macro: grant=0001 persists for 100 cycles.
